// File: rtl/ahfp_pkg.sv
// rtl/ahfp_pkg.sv - shared widths, constants and stage payload type for the ahfp datapath
package ahfp_pkg;
    localparam int AHFP_MW   = 48;
    localparam int AHFP_EW   = 8;
    localparam int AHFP_FW   = 23;
    localparam int AHFP_XW   = 10;
    localparam int AHFP_LZW  = 6;
    localparam int AHFP_BIAS = 127;
    localparam int AHFP_EMAX = 255;

    // exp is carried one bit wider than the input so stage 2 can hold in_exp + 1 - lz
    typedef struct packed {
        logic                 sign;
        logic [AHFP_XW:0]     exp;
        logic [AHFP_MW-1:0]   mant;
        logic                 zero;
    } stage_t;
endpackage

// File: rtl/ahfp_lzd48.sv
// rtl/ahfp_lzd48.sv - leading-zero count of a 48-bit mantissa (47 when the input is zero)
module ahfp_lzd48
    import ahfp_pkg::*;
(
    input  logic [AHFP_MW-1:0]  i_mant,
    output logic [AHFP_LZW-1:0] o_lz
);
    always_comb begin
        o_lz = 6'd47;
        for (int i = 0; i < AHFP_MW; i++) begin
            if (i_mant[i]) begin
                o_lz = 6'(47 - i);
            end
        end
    end
endmodule

// File: rtl/ahfp_round_pack.sv
// rtl/ahfp_round_pack.sv - round-to-nearest-even and single-precision packing of a normalised mantissa
module ahfp_round_pack
    import ahfp_pkg::*;
(
    input  logic                i_sign,
    input  logic [AHFP_XW:0]    i_exp,
    input  logic [AHFP_MW-1:0]  i_mant,
    input  logic                i_zero,
    output logic                o_sign,
    output logic [AHFP_EW-1:0]  o_exp,
    output logic [AHFP_FW-1:0]  o_frac,
    output logic                o_zero,
    output logic                o_uflow,
    output logic                o_oflow
);
    logic                w_guard;
    logic                w_sticky;
    logic                w_rnd;
    logic                w_carry;
    logic [AHFP_FW-1:0]  w_frac;
    logic [AHFP_XW:0]    w_e;

    assign w_guard  = i_mant[23];
    assign w_sticky = |i_mant[22:0];
    assign w_rnd    = w_guard & (w_sticky | i_mant[24]);
    // the hidden bit is n[47]; an all-ones kept field wraps the fraction to zero on carry-out
    assign w_carry  = (&i_mant[47:24]) & w_rnd;
    assign w_frac   = i_mant[46:24] + {22'd0, w_rnd};
    assign w_e      = i_exp + {10'd0, w_carry};

    always_comb begin
        o_sign  = i_sign;
        o_exp   = '0;
        o_frac  = '0;
        o_zero  = 1'b0;
        o_uflow = 1'b0;
        o_oflow = 1'b0;
        if (i_zero) begin
            o_zero = 1'b1;
        end else if ($signed(w_e) >= $signed(11'(AHFP_EMAX))) begin
            o_exp   = 8'(AHFP_EMAX);
            o_oflow = 1'b1;
        end else if ($signed(w_e) <= $signed(11'd0)) begin
            o_uflow = 1'b1;
        end else begin
            o_exp  = w_e[7:0];
            o_frac = w_frac;
        end
    end
endmodule

// File: rtl/ahfp_norm48.sv
// rtl/ahfp_norm48.sv - three-stage normalise/round/pack pipeline with a global valid/ready stall
module ahfp_norm48
    import ahfp_pkg::*;
#(
    parameter int MW = AHFP_MW,
    parameter int EW = AHFP_EW,
    parameter int FW = AHFP_FW,
    parameter int XW = AHFP_XW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_sign,
    input  logic [XW-1:0] in_exp,
    input  logic [MW-1:0] in_mant,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_sign,
    output logic [EW-1:0] out_exp,
    output logic [FW-1:0] out_frac,
    output logic          out_zero,
    output logic          out_uflow,
    output logic          out_oflow
);
    logic                w_en;
    logic [AHFP_LZW-1:0] w_lz;
    logic [AHFP_XW:0]    w_s2_exp;
    logic [AHFP_MW-1:0]  w_s2_mant;

    logic                w_rp_sign;
    logic [AHFP_EW-1:0]  w_rp_exp;
    logic [AHFP_FW-1:0]  w_rp_frac;
    logic                w_rp_zero;
    logic                w_rp_uflow;
    logic                w_rp_oflow;

    stage_t              r_s1;
    logic [AHFP_LZW-1:0] r_s1_lz;
    logic                r_s1_valid;
    stage_t              r_s2;
    logic                r_s2_valid;

    logic                r_out_valid;
    logic                r_out_sign;
    logic [EW-1:0]       r_out_exp;
    logic [FW-1:0]       r_out_frac;
    logic                r_out_zero;
    logic                r_out_uflow;
    logic                r_out_oflow;

    // whole pipe freezes while a result is held, so bubbles keep their slots
    assign w_en     = !r_out_valid | out_ready;
    assign in_ready = w_en;

    ahfp_lzd48 u_lzd (
        .i_mant (in_mant),
        .o_lz   (w_lz)
    );

    assign w_s2_mant = r_s1.mant << r_s1_lz;
    assign w_s2_exp  = r_s1.exp + 11'd1 - {5'd0, r_s1_lz};

    ahfp_round_pack u_round_pack (
        .i_sign  (r_s2.sign),
        .i_exp   (r_s2.exp),
        .i_mant  (r_s2.mant),
        .i_zero  (r_s2.zero),
        .o_sign  (w_rp_sign),
        .o_exp   (w_rp_exp),
        .o_frac  (w_rp_frac),
        .o_zero  (w_rp_zero),
        .o_uflow (w_rp_uflow),
        .o_oflow (w_rp_oflow)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1        <= '0;
            r_s1_lz     <= '0;
            r_s2_valid  <= 1'b0;
            r_s2        <= '0;
            r_out_valid <= 1'b0;
            r_out_sign  <= 1'b0;
            r_out_exp   <= '0;
            r_out_frac  <= '0;
            r_out_zero  <= 1'b0;
            r_out_uflow <= 1'b0;
            r_out_oflow <= 1'b0;
        end else if (w_en) begin
            r_s1_valid  <= in_valid;
            r_s1.sign   <= in_sign;
            r_s1.exp    <= {in_exp[XW-1], in_exp};
            r_s1.mant   <= in_mant;
            r_s1.zero   <= (in_mant == '0);
            r_s1_lz     <= w_lz;

            r_s2_valid  <= r_s1_valid;
            r_s2.sign   <= r_s1.sign;
            r_s2.exp    <= w_s2_exp;
            r_s2.mant   <= w_s2_mant;
            r_s2.zero   <= r_s1.zero;

            r_out_valid <= r_s2_valid;
            r_out_sign  <= w_rp_sign;
            r_out_exp   <= w_rp_exp;
            r_out_frac  <= w_rp_frac;
            r_out_zero  <= w_rp_zero;
            r_out_uflow <= w_rp_uflow;
            r_out_oflow <= w_rp_oflow;
        end
    end

    assign out_valid = r_out_valid;
    assign out_sign  = r_out_sign;
    assign out_exp   = r_out_exp;
    assign out_frac  = r_out_frac;
    assign out_zero  = r_out_zero;
    assign out_uflow = r_out_uflow;
    assign out_oflow = r_out_oflow;
endmodule
